ksa_shuffle_responder: RTL and testbench
========================================

Name: ksa_shuffle_responder

Overview:
- Responder side of the task start/finish handshake issued by the decode-using-key sequencer. It implements the RC4 key-scheduling (shuffle) task.
- On a one-cycle `start` pulse it latches the secret key and performs the 256-iteration swap loop on the shared S-box RAM (`j = j + S[i] + key[i mod KEY_BYTES]`, then swap `S[i]` and `S[j]`).
- It returns a one-cycle `finish` pulse when done.
- It drives the S-box RAM port only while `select_task` grants it the shuffle slot. The mux sits outside this block.

Parameters:
- KEY_BYTES, 3, number of secret-key bytes. Legal range 1..8.
- KEY_W, 8*KEY_BYTES, width of `secret_key` (derived; do not override).

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- start  input  1  one-cycle start pulse from the sequencer
- secret_key  input  KEY_W  key; byte 0 = `secret_key[KEY_W-1:KEY_W-8]` (MSB byte first)
- mem_q  input  8  S-box RAM read data
- mem_addr  output  8  S-box RAM address
- mem_data  output  8  S-box RAM write data
- mem_wren  output  1  S-box RAM write enable
- busy  output  1  high from the first operation cycle through the DONE cycle
- finish  output  1  one-cycle completion pulse to the sequencer

Behaviour:
- Reset values (cycle after `reset` is sampled high): state IDLE, `i`=0, `j`=0, key index `k`=0, `mem_addr`=0, `mem_data`=0, `mem_wren`=0, `busy`=0, `finish`=0.
- Reset has priority over `start` and over any in-progress operation.
- Reset mid-operation: return to IDLE next cycle with no further writes. RAM contents are left partially shuffled; they are not restored.
- RAM timing: the address presented in cycle N gives valid `mem_q` in cycle N+1. The block captures `mem_q` at the end of cycle N+1. A write occurs at the end of a cycle with `mem_wren`=1.
- Key bytes are latched into an internal register in the cycle `start` is accepted. `secret_key` is ignored afterwards.
- `start` is accepted only in IDLE. Pulses while busy are ignored; the operation does not restart.
- States and per-state outputs (`mem_wren`=0 unless noted):
  - IDLE: `mem_addr`=0. On `start`, go to RD_SI with `i`=0, `j`=0, `k`=0.
  - RD_SI: `mem_addr`=`i`. Go to LD_SI.
  - LD_SI: `si`<=`mem_q`; `j`<=(`j` + `mem_q` + keybyte[`k`]) mod 256 (8-bit wrap). Go to RD_SJ.
  - RD_SJ: `mem_addr`=`j` (the new `j`). Go to LD_SJ.
  - LD_SJ: `sj`<=`mem_q`. Go to WR_SI.
  - WR_SI: `mem_addr`=`i`, `mem_data`=`sj`, `mem_wren`=1. Go to WR_SJ.
  - WR_SJ: `mem_addr`=`j`, `mem_data`=`si`, `mem_wren`=1.
    - If `i`==255, go to DONE.
    - Otherwise `i`<=`i`+1 and `k`<=(`k`==KEY_BYTES-1) ? 0 : `k`+1 (no divider), then go to RD_SI.
  - DONE: `finish`=1 for exactly this cycle, then IDLE.
- Latency: `start` sampled in cycle 0 gives operation cycles 1..1536 (6 per iteration × 256), DONE/`finish` in cycle 1537, and IDLE in cycle 1538.
- `i`==`j` case: both writes target the same address with the same value; the net effect is a no-op and no special case is required.
- `j` wrap-around: sums of 256 or more wrap modulo 256.
- `i` is 8 bits; the loop terminates on `i`==255, not on overflow.
- `start` arriving in the same cycle as DONE is ignored. `start` in the first IDLE cycle after DONE is accepted.

Test Plan:
- Reset hold: assert `reset` 3 cycles with `start` pulsed during reset -> `mem_wren`=0, `finish`=0, `busy`=0 throughout and after. No RAM writes.
- Key 0x010203, identity S-box -> cycle 5: `mem_addr`=0, `mem_data`=1, `mem_wren`=1. Cycle 6: `mem_addr`=1, `mem_data`=0, `mem_wren`=1. Afterwards S[0]=1, S[1]=0.
- Key 0x000000, identity S-box -> after iteration `i`=2, S[2]=3 and S[3]=2. Iterations 0 and 1 leave S[0]=0 and S[1]=1.
- Full run with key 0x000249 vs. a bench reference KSA model -> all 256 RAM bytes match. `finish` is high only in cycle 1537; `busy` is high for cycles 1..1537.
- `start` re-pulsed at cycles 10 and 800 -> ignored; `finish` still occurs only at cycle 1537, and the write trace is identical to a single-start run.
- Reset asserted at cycle 700 -> `mem_wren`=0 from cycle 701. A new `start` at cycle 705 yields `finish` at cycle 705+1537.

Source files
------------

// File: rtl/ksa_shuffle_responder.sv
// RC4 key-scheduling responder: on a start pulse, runs the 256-iteration swap
// loop over the shared S-box RAM and returns a one-cycle finish pulse.
module ksa_shuffle_responder #(
    parameter  int KEY_BYTES = 3,
    localparam int KEY_W     = 8*KEY_BYTES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [KEY_W-1:0] secret_key,
    input  logic [7:0]       mem_q,
    output logic [7:0]       mem_addr,
    output logic [7:0]       mem_data,
    output logic             mem_wren,
    output logic             busy,
    output logic             finish
);

    typedef enum logic [2:0] {
        IDLE, RD_SI, LD_SI, RD_SJ, LD_SJ, WR_SI, WR_SJ, DONE
    } state_t;

    state_t      r_state, w_next;
    logic [7:0]  r_i, r_j, r_si, r_sj;
    logic [2:0]  r_k;
    logic [7:0]  r_key [KEY_BYTES];
    logic [7:0]  w_keybyte;
    logic        w_accept;
    logic        w_last;

    assign w_accept  = (r_state == IDLE) && start;
    assign w_last    = (r_i == 8'hFF);
    assign w_keybyte = r_key[r_k];

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RD_SI;
            RD_SI:   w_next = LD_SI;
            LD_SI:   w_next = RD_SJ;
            RD_SJ:   w_next = LD_SJ;
            LD_SJ:   w_next = WR_SI;
            WR_SI:   w_next = WR_SJ;
            WR_SJ:   w_next = w_last ? DONE : RD_SI;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        mem_addr = 8'h00;
        mem_data = 8'h00;
        mem_wren = 1'b0;
        busy     = (r_state != IDLE);
        finish   = (r_state == DONE);
        case (r_state)
            RD_SI:   mem_addr = r_i;
            RD_SJ:   mem_addr = r_j;
            WR_SI:   begin mem_addr = r_i; mem_data = r_sj; mem_wren = 1'b1; end
            WR_SJ:   begin mem_addr = r_j; mem_data = r_si; mem_wren = 1'b1; end
            default: ;
        endcase
    end

    // Key is held internally so the sequencer may change secret_key mid-run.
    always_ff @(posedge clk) begin
        if (!reset && w_accept)
            for (int b = 0; b < KEY_BYTES; b++)
                r_key[b] <= secret_key[KEY_W-1-8*b -: 8];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_i  <= 8'h00;
            r_j  <= 8'h00;
            r_k  <= 3'd0;
            r_si <= 8'h00;
            r_sj <= 8'h00;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_i <= 8'h00;
                    r_j <= 8'h00;
                    r_k <= 3'd0;
                end
                LD_SI: begin
                    r_si <= mem_q;
                    r_j  <= r_j + mem_q + w_keybyte;
                end
                LD_SJ: r_sj <= mem_q;
                // Key index wraps by compare so no modulo divider is needed.
                WR_SJ: if (!w_last) begin
                    r_i <= r_i + 8'd1;
                    r_k <= (r_k == 3'(KEY_BYTES-1)) ? 3'd0 : r_k + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ksa_shuffle_responder.sv
// Bench for ksa_shuffle_responder: behavioural RAM with one-cycle read latency
// and a plain-arithmetic RC4 KSA reference model.
module tb_ksa_shuffle_responder;

    localparam int KB = 3;
    localparam int NT = 2400;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [23:0] secret_key;
    logic [7:0]  mem_q, mem_addr, mem_data;
    logic        mem_wren, busy, finish;

    always #5 clk = ~clk;

    ksa_shuffle_responder #(.KEY_BYTES(KB)) dut (
        .clk(clk), .reset(reset), .start(start), .secret_key(secret_key),
        .mem_q(mem_q), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_wren(mem_wren), .busy(busy), .finish(finish)
    );

    logic [7:0] ram [256];
    logic [7:0] img [256];
    logic       ram_load;

    always @(posedge clk) begin
        mem_q <= ram[mem_addr];
        if (ram_load) for (int a = 0; a < 256; a++) ram[a] <= img[a];
        else if (mem_wren) ram[mem_addr] <= mem_data;
    end

    int n_cmp = 0;
    int n_err = 0;

    logic       tr_w [NT];
    logic       tr_b [NT];
    logic       tr_f [NT];
    logic [7:0] tr_a [NT];
    logic [7:0] tr_d [NT];
    logic [7:0] snap [256];

    logic [7:0] m_s  [256];
    logic [7:0] m_wa [512];
    logic [7:0] m_wd [512];

    task automatic set_identity();
        for (int a = 0; a < 256; a++) img[a] = 8'(a);
    endtask

    task automatic set_random_perm();
        int b;
        logic [7:0] t;
        set_identity();
        for (int a = 255; a > 0; a--) begin
            b = $urandom_range(a, 0);
            t = img[a]; img[a] = img[b]; img[b] = t;
        end
    endtask

    task automatic load_img();
        @(negedge clk); ram_load = 1'b1;
        @(negedge clk); ram_load = 1'b0;
        for (int a = 0; a < 256; a++) m_s[a] = img[a];
    endtask

    // Reference KSA on m_s; also lists the 512 expected RAM writes in order.
    task automatic ksa_model(input logic [23:0] key);
        logic [7:0] j, t;
        j = 8'h00;
        for (int i = 0; i < 256; i++) begin
            j = j + m_s[i] + key[23-8*(i%KB) -: 8];
            m_wa[2*i]   = 8'(i);  m_wd[2*i]   = m_s[j];
            m_wa[2*i+1] = j;      m_wd[2*i+1] = m_s[i];
            t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
        end
    endtask

    // Cycle 0 samples start; records outputs of cycles 1..n. Extra start
    // pulses at p1/p2, a one-cycle reset at rc, RAM snapshot at snapc.
    task automatic run_capture(input logic [23:0] key, input int p1, input int p2,
                               input int rc, input int snapc, input int n);
        @(negedge clk);
        secret_key = key; start = 1'b1;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            start      = (c == p1) || (c == p2);
            secret_key = start ? key : 24'($urandom);
            reset      = (c == rc);
            tr_w[c] = mem_wren; tr_b[c] = busy; tr_f[c] = finish;
            tr_a[c] = mem_addr; tr_d[c] = mem_data;
            if (c == snapc) for (int a = 0; a < 256; a++) snap[a] = ram[a];
        end
        start = 1'b0; reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0;
        set_identity();
        load_img();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            start = (c == 1);
            if (c == 3) reset = 1'b0;
            n_cmp++;
            if ({mem_wren, finish, busy} !== 3'b000 || mem_addr !== 8'h00 || mem_data !== 8'h00) begin
                n_err++;
                $display("FAIL reset_hold c=%0d: wren/fin/busy=%b addr=%h data=%h, want 000/00/00",
                         c, {mem_wren, finish, busy}, mem_addr, mem_data);
            end
        end
        for (int a = 0; a < 256; a++) begin
            n_cmp++;
            if (ram[a] !== 8'(a)) begin
                n_err++;
                if (n_err < 30) $display("FAIL reset_ram S[%0d]=%h want %h", a, ram[a], 8'(a));
            end
        end
    endtask

    task automatic test_first_iter();
        set_identity();
        load_img();
        run_capture(24'h010203, -1, -1, -1, 7, 1540);
        n_cmp++;
        if ({tr_w[5], tr_a[5], tr_d[5]} !== {1'b1, 8'h00, 8'h01}) begin
            n_err++;
            $display("FAIL first_wr_c5 wren=%b addr=%h data=%h want 1/00/01", tr_w[5], tr_a[5], tr_d[5]);
        end
        n_cmp++;
        if ({tr_w[6], tr_a[6], tr_d[6]} !== {1'b1, 8'h01, 8'h00}) begin
            n_err++;
            $display("FAIL first_wr_c6 wren=%b addr=%h data=%h want 1/01/00", tr_w[6], tr_a[6], tr_d[6]);
        end
        n_cmp++;
        if (snap[0] !== 8'h01 || snap[1] !== 8'h00) begin
            n_err++;
            $display("FAIL first_swap S0=%h S1=%h want 01/00", snap[0], snap[1]);
        end
    endtask

    task automatic test_key_zero();
        set_identity();
        load_img();
        run_capture(24'h000000, -1, -1, -1, 19, 1540);
        n_cmp++;
        if ({snap[0], snap[1], snap[2], snap[3]} !== 32'h00_01_03_02) begin
            n_err++;
            $display("FAIL key_zero S0..3=%h %h %h %h want 00 01 03 02",
                     snap[0], snap[1], snap[2], snap[3]);
        end
    endtask

    task automatic test_full_run(input logic [23:0] key, input bit rnd);
        int  wi;
        logic ew;
        if (rnd) set_random_perm(); else set_identity();
        load_img();
        ksa_model(key);
        run_capture(key, -1, -1, -1, -1, 1540);
        wi = 0;
        for (int c = 1; c <= 1540; c++) begin
            ew = (c <= 1536) && ((c-1) % 6 >= 4);
            n_cmp++;
            if (tr_w[c] !== ew || tr_b[c] !== (c <= 1537) || tr_f[c] !== (c == 1537)) begin
                n_err++;
                if (n_err < 30) $display("FAIL full_ctl key=%h c=%0d wren/busy/fin=%b%b%b want %b%b%b",
                    key, c, tr_w[c], tr_b[c], tr_f[c], ew, (c <= 1537), (c == 1537));
            end
            if (ew) begin
                n_cmp++;
                if (tr_a[c] !== m_wa[wi] || tr_d[c] !== m_wd[wi]) begin
                    n_err++;
                    if (n_err < 30) $display("FAIL full_wr key=%h c=%0d addr=%h data=%h want %h/%h",
                        key, c, tr_a[c], tr_d[c], m_wa[wi], m_wd[wi]);
                end
                wi++;
            end
        end
        for (int a = 0; a < 256; a++) begin
            n_cmp++;
            if (ram[a] !== m_s[a]) begin
                n_err++;
                if (n_err < 30) $display("FAIL full_ram key=%h S[%0d]=%h want %h", key, a, ram[a], m_s[a]);
            end
        end
    endtask

    task automatic test_restart_ignored();
        int wi;
        logic [23:0] key;
        key = 24'($urandom);
        set_identity();
        load_img();
        ksa_model(key);
        run_capture(key ^ 24'h5A5A5A, -1, -1, -1, -1, 0);
        run_capture(key, 10, 800, -1, -1, 1540);
        wi = 0;
        for (int c = 1; c <= 1540; c++) begin
            n_cmp++;
            if (tr_f[c] !== (c == 1537)) begin
                n_err++;
                if (n_err < 30) $display("FAIL restart_fin c=%0d finish=%b want %b", c, tr_f[c], (c == 1537));
            end
            if (tr_w[c] === 1'b1) begin
                n_cmp++;
                if (wi >= 512 || tr_a[c] !== m_wa[wi] || tr_d[c] !== m_wd[wi]) begin
                    n_err++;
                    if (n_err < 30) $display("FAIL restart_wr c=%0d addr=%h data=%h want write #%0d",
                                             c, tr_a[c], tr_d[c], wi);
                end
                wi++;
            end
        end
        n_cmp++;
        if (wi != 512) begin
            n_err++;
            $display("FAIL restart_nwr writes=%0d want 512", wi);
        end
    endtask

    task automatic test_done_boundary();
        set_identity();
        load_img();
        run_capture(24'h123456, 1537, 1538, -1, -1, 1541);
        n_cmp++;
        if (tr_f[1537] !== 1'b1 || tr_f[1538] !== 1'b0 || tr_b[1538] !== 1'b0) begin
            n_err++;
            $display("FAIL done_start fin1537=%b fin1538=%b busy1538=%b want 1/0/0",
                     tr_f[1537], tr_f[1538], tr_b[1538]);
        end
        n_cmp++;
        if (tr_b[1539] !== 1'b1 || tr_a[1539] !== 8'h00 || tr_b[1540] !== 1'b1) begin
            n_err++;
            $display("FAIL idle_start busy1539=%b addr1539=%h busy1540=%b want 1/00/1",
                     tr_b[1539], tr_a[1539], tr_b[1540]);
        end
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_reset_midop();
        logic [23:0] key;
        key = 24'($urandom);
        set_identity();
        load_img();
        run_capture(key, 705, -1, 700, 704, 2245);
        for (int c = 701; c <= 705; c++) begin
            n_cmp++;
            if (tr_w[c] !== 1'b0 || tr_b[c] !== 1'b0) begin
                n_err++;
                $display("FAIL midop_reset c=%0d wren=%b busy=%b want 0/0", c, tr_w[c], tr_b[c]);
            end
        end
        for (int a = 0; a < 256; a++) m_s[a] = snap[a];
        ksa_model(key);
        for (int c = 706; c <= 2245; c++) begin
            n_cmp++;
            if (tr_f[c] !== (c == 2242) || tr_b[c] !== (c <= 2242)) begin
                n_err++;
                if (n_err < 30) $display("FAIL midop_rerun c=%0d fin=%b busy=%b want %b/%b",
                                         c, tr_f[c], tr_b[c], (c == 2242), (c <= 2242));
            end
        end
        for (int a = 0; a < 256; a++) begin
            n_cmp++;
            if (ram[a] !== m_s[a]) begin
                n_err++;
                if (n_err < 30) $display("FAIL midop_ram S[%0d]=%h want %h", a, ram[a], m_s[a]);
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; secret_key = 24'h0; ram_load = 1'b0;
        test_reset();
        test_first_iter();
        test_key_zero();
        test_full_run(24'h000249, 1'b0);
        test_full_run(24'($urandom), 1'b1);
        test_restart_ignored();
        test_done_boundary();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
